i2c_bus_monitor: RTL
====================

# i2c_bus_monitor

Passive I2C bus decoder on the same `SCL`/`SDA_OUT`/`SDA_OE`/`SDA_IN` wires that connect `generador_transacciones` and `receptor_transacciones`. It never drives the bus. It rebuilds each frame (7-bit address, RNW, up to two data bytes, one ACK bit per phase) and reports it as a single-cycle record. It is the reader for the generator's writer, and serves as an in-bench checker and a debug tap on silicon.

## Interface
- `DATA_BYTES`, default 2: data bytes in a complete frame, legal range 1..2.
- `clk`  in  1  system clock; the same clock that drives the generator.
- `rst`  in  1  asynchronous reset, active-high.
- `SCL`  in  1  bus clock from the generator.
- `SDA_OUT`  in  1  generator SDA output value.
- `SDA_OE`  in  1  generator SDA output enable.
- `SDA_IN`  in  1  SDA value driven by the target.
- `MON_VALID`  out  1  one-cycle pulse: a frame record is valid.
- `MON_ADDR`  out  7  decoded target address.
- `MON_RNW`  out  1  decoded R/W bit; 1 means read.
- `MON_DATA`  out  16  decoded data, first byte in [15:8].
- `MON_ACK`  out  3  ACK bits; [2] address, [1] byte 1, [0] byte 2; 1 means NACK.
- `MON_NBYTES`  out  2  number of complete data bytes received (0..2).
- `MON_ERR`  out  1  frame was malformed.
- `MON_BUSY`  out  1  high between START and STOP/abort.

## Operation
- Effective line: `sda = SDA_OE ? SDA_OUT : SDA_IN`.
- Registered copies `scl_q` and `sda_q` are used for edge detection.
- START: `scl_q=1`, `SCL=1`, `sda_q=1`, `sda=0`.
- STOP: `scl_q=1`, `SCL=1`, `sda_q=0`, `sda=1`.
- Bit sample: the `SCL` rising edge (`scl_q=0`, `SCL=1`) samples `sda`. Data is MSB first.
- States:
  - IDLE. START leads to ADDR. All other activity is ignored.
  - ADDR. Eight samples go into {addr, rnw}, then ACK_A.
  - ACK_A. One sample goes to `MON_ACK[2]`. ACK leads to DATA. NACK leads to WAIT_STOP.
  - DATA. Eight samples shift into the current byte, then ACK_D.
  - ACK_D. One sample goes to the `MON_ACK` bit for this byte and increments the byte count. If the count equals `DATA_BYTES`, or the bit is NACK, go to WAIT_STOP; otherwise go to DATA.
  - WAIT_STOP. Any further `SCL` rising edge sets a sticky overrun flag.
- STOP in any non-IDLE state ends the frame: emit the record and go to IDLE.
- Repeated START in any non-IDLE state: emit the record for the current frame, then go to ADDR with all fields cleared.
- `MON_ERR=1` when the frame ends outside WAIT_STOP (truncated), or when the overrun flag is set.
- NACK termination is legal and gives `MON_ERR=0`.
- Truncated frame contents:
  - Complete fields keep their values.
  - A partial byte is discarded and reads as 0.
  - `MON_ACK` bits that were never sampled read as 0.
- `MON_NBYTES` counts only bytes whose ACK bit was sampled.
- Record outputs hold their values until the next record. Only `MON_VALID` pulses.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-frame discards the frame; no `MON_VALID` is produced.
- `MON_BUSY` rises in cycle c+1, where cycle c is the clock in which START is detected.
- STOP detected in cycle c:
  - `MON_VALID=1` and the record is updated in cycle c+1.
  - `MON_VALID=0` in cycle c+2.
  - `MON_BUSY=0` from cycle c+1.
- Repeated START in cycle c: `MON_VALID` in cycle c+1; `MON_BUSY` stays 1.
- START and a bit sample never occur in the same cycle, because they need `scl_q` at different values. No priority rule is needed.
- `SCL` high time must be at least 2 `clk` cycles. The generator's divided `SCL` meets this.

## Configuration
- `I2C_MON_SYNC_EN` defined: a 2-flop synchronizer is placed on each of `SCL`, `SDA_OUT`, `SDA_OE`, `SDA_IN` ahead of edge detection. Every latency above grows by exactly 2 cycles. Synchronizer flops reset to 1 for SCL/SDA and 0 for OE.
- Not defined: inputs feed edge detection directly. Only legal when the bus is generated in the `clk` domain.

## Test plan
- Write to address 0x55, data 0xA5C3, all ACKs:
  - exactly one `MON_VALID`, one cycle after STOP;
  - record: ADDR=0x55, RNW=0, DATA=0xA5C3, ACK=3'b000, NBYTES=2, ERR=0.
- Read from 0x2A, target returns 0x1234, master NACKs the last byte:
  - record: RNW=1, DATA=0x1234, ACK=3'b001, NBYTES=2, ERR=0.
- Address 0x11 NACKed, generator sends STOP:
  - record: ADDR=0x11, ACK=3'b100, NBYTES=0, DATA=0, ERR=0.
- STOP forced after 12 `SCL` bits (address phase and ACK complete, 3 data bits):
  - record: NBYTES=0, DATA=0, ERR=1.
  - A nine-`SCL` write frame is then monitored correctly.
- `rst` pulsed for 1 cycle during byte 1:
  - all outputs are 0 next cycle and no `MON_VALID` is produced;
  - the following complete frame decodes correctly.
- Same first scenario with `I2C_MON_SYNC_EN` defined: identical record, with `MON_VALID` 3 cycles after STOP.

Source files
------------

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C frame decoder. It watches the generator/target
// SDA wires plus SCL, rebuilds address, R/W, up to DATA_BYTES data bytes and
// the ACK bits, and emits one record per frame on a single-cycle MON_VALID.
// Optional build macro I2C_MON_SYNC_EN inserts 2-flop synchronizers on all
// bus inputs (every latency grows by 2 clk cycles).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting 7 address bits + R/W
// ACK_A     | sampling the address ACK
// DATA      | shifting the current data byte
// ACK_D     | sampling the ACK of the current data byte
// WAIT_STOP | frame complete, waiting for STOP; extra clocks flag overrun
`timescale 1ns/1ps

module i2c_bus_monitor #(
  parameter int DATA_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  input  logic        SDA_OUT,
  input  logic        SDA_OE,
  input  logic        SDA_IN,
  output logic        MON_VALID,
  output logic [6:0]  MON_ADDR,
  output logic        MON_RNW,
  output logic [15:0] MON_DATA,
  output logic [2:0]  MON_ACK,
  output logic [1:0]  MON_NBYTES,
  output logic        MON_ERR,
  output logic        MON_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_DATA,
    S_ACK_D,
    S_WAIT_STOP
  } state_t;

  localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES);

  logic scl_s, sdo_s, oe_s, sdi_s, sda_s;

`ifdef I2C_MON_SYNC_EN
  logic [1:0] scl_sync_q, sdo_sync_q, oe_sync_q, sdi_sync_q;

  // Two-flop synchronizers; reset to the idle bus levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sdo_sync_q <= 2'b11;
      oe_sync_q  <= 2'b00;
      sdi_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sdo_sync_q <= {sdo_sync_q[0], SDA_OUT};
      oe_sync_q  <= {oe_sync_q[0], SDA_OE};
      sdi_sync_q <= {sdi_sync_q[0], SDA_IN};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sdo_s = sdo_sync_q[1];
  assign oe_s  = oe_sync_q[1];
  assign sdi_s = sdi_sync_q[1];
`else
  assign scl_s = SCL;
  assign sdo_s = SDA_OUT;
  assign oe_s  = SDA_OE;
  assign sdi_s = SDA_IN;
`endif

  assign sda_s = oe_s ? sdo_s : sdi_s;

  logic scl_q, sda_q;

  // Previous-cycle copies of the bus lines for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic start_det, stop_det, scl_rise, scl_fall;

  assign start_det = scl_q & scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_q & scl_s & ~sda_q & sda_s;
  assign scl_rise  = ~scl_q & scl_s;
  assign scl_fall  = scl_q & ~scl_s;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [6:0]  addr_q;
  logic        rnw_q;
  logic [15:0] data_q;
  logic [2:0]  ack_q;
  logic [1:0]  nbytes_q;
  logic        ovr_pend_q;
  logic        ovr_q;
  logic        last_byte;
  logic        frame_end;

  assign last_byte = (nbytes_q + 2'd1) == LAST_BYTE;
  assign frame_end = (state_q != S_IDLE) && (start_det || stop_det);
  assign MON_BUSY  = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: STOP / repeated START win over bit sampling in any active state.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start_det) state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR:  if (bit_cnt_q == 3'd7) state_d = S_ACK_A;
        S_ACK_A: state_d = sda_s ? S_WAIT_STOP : S_DATA;
        S_DATA:  if (bit_cnt_q == 3'd7) state_d = S_ACK_D;
        S_ACK_D: state_d = (sda_s || last_byte) ? S_WAIT_STOP : S_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  // Frame field capture. A byte is committed only once all 8 bits are in, so a
  // partial byte reads as 0. In WAIT_STOP the SCL rise that precedes a STOP is
  // part of the STOP condition itself, so overrun needs a full extra pulse
  // (rise then fall) before it is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      addr_q     <= 7'd0;
      rnw_q      <= 1'b0;
      data_q     <= 16'd0;
      ack_q      <= 3'd0;
      nbytes_q   <= 2'd0;
      ovr_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (start_det) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      addr_q     <= 7'd0;
      rnw_q      <= 1'b0;
      data_q     <= 16'd0;
      ack_q      <= 3'd0;
      nbytes_q   <= 2'd0;
      ovr_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (scl_rise && !stop_det) begin
      case (state_q)
        S_ADDR: begin
          shift_q   <= {shift_q[5:0], sda_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_q <= shift_q;
            rnw_q  <= sda_s;
          end
        end
        S_ACK_A: begin
          ack_q[2]  <= sda_s;
          bit_cnt_q <= 3'd0;
        end
        S_DATA: begin
          shift_q   <= {shift_q[5:0], sda_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (nbytes_q == 2'd0) data_q[15:8] <= {shift_q, sda_s};
            else                  data_q[7:0]  <= {shift_q, sda_s};
          end
        end
        S_ACK_D: begin
          if (nbytes_q == 2'd0) ack_q[1] <= sda_s;
          else                  ack_q[0] <= sda_s;
          nbytes_q  <= nbytes_q + 2'd1;
          bit_cnt_q <= 3'd0;
        end
        S_WAIT_STOP: ovr_pend_q <= 1'b1;
        default: ;
      endcase
    end else if (scl_fall && ovr_pend_q && state_q == S_WAIT_STOP) begin
      ovr_q <= 1'b1;
    end
  end

  logic        rec_valid_d;
  logic [6:0]  rec_addr_d;
  logic        rec_rnw_d;
  logic [15:0] rec_data_d;
  logic [2:0]  rec_ack_d;
  logic [1:0]  rec_nbytes_d;
  logic        rec_err_d;

  // Record outputs: load the finished frame on STOP / repeated START, else hold.
  always_comb begin
    rec_valid_d  = 1'b0;
    rec_addr_d   = MON_ADDR;
    rec_rnw_d    = MON_RNW;
    rec_data_d   = MON_DATA;
    rec_ack_d    = MON_ACK;
    rec_nbytes_d = MON_NBYTES;
    rec_err_d    = MON_ERR;
    if (frame_end) begin
      rec_valid_d  = 1'b1;
      rec_addr_d   = addr_q;
      rec_rnw_d    = rnw_q;
      rec_data_d   = data_q;
      rec_ack_d    = ack_q;
      rec_nbytes_d = nbytes_q;
      rec_err_d    = (state_q != S_WAIT_STOP) || ovr_q;
    end
  end

  // Registered record outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MON_VALID  <= 1'b0;
      MON_ADDR   <= 7'd0;
      MON_RNW    <= 1'b0;
      MON_DATA   <= 16'd0;
      MON_ACK    <= 3'd0;
      MON_NBYTES <= 2'd0;
      MON_ERR    <= 1'b0;
    end else begin
      MON_VALID  <= rec_valid_d;
      MON_ADDR   <= rec_addr_d;
      MON_RNW    <= rec_rnw_d;
      MON_DATA   <= rec_data_d;
      MON_ACK    <= rec_ack_d;
      MON_NBYTES <= rec_nbytes_d;
      MON_ERR    <= rec_err_d;
    end
  end

endmodule
